writeback_unit: RTL and testbench

Writeback stage of the RISC CPU: the single writer driving the register file's `rd`/`result`/`reg_write` port. Merges single-cycle ALU results with long-latency load/store-unit (LSU) results, buffering LSU results in a small FIFO so the ALU never stalls. Keeps a per-register pending scoreboard so decode can stall instructions whose source registers await an LSU result.

---
 rtl/writeback_unit.sv | 127 ++++++++++++
 tb/tb_writeback_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results with buffered LSU results into the
// register file write port and tracks registers awaiting LSU results.
module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_result,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [XLEN-1:0]               lsu_result,
  input  logic                          issue_set,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    chk_rs1,
  input  logic [4:0]                    chk_rs2,
  output logic                          busy_rs1,
  output logic                          busy_rs2,
  output logic [4:0]                    rd,
  output logic [XLEN-1:0]               result,
  output logic                          reg_write,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pending_q, pending_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            we_q, we_d;

  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign lsu_ready = !rst && (count_q < FULL);
  assign push      = lsu_valid && lsu_ready;
  assign pop       = !rst && !alu_valid && (count_q != '0);
  assign head_rd   = fifo_rd_q[rptr_q];
  assign head_data = fifo_data_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ALU has fixed priority; the FIFO drains only on ALU-idle cycles
  always_comb begin
    rd_d     = rd_q;
    result_d = result_q;
    we_d     = 1'b0;
    if (alu_valid) begin
      rd_d     = alu_rd;
      result_d = alu_result;
      we_d     = (alu_rd != 5'd0);
    end else if (pop) begin
      rd_d     = head_rd;
      result_d = head_data;
      we_d     = (head_rd != 5'd0);
    end
  end

  // clear before set so a same-cycle issue to the popped rd stays pending
  always_comb begin
    pending_d = pending_q;
    if (pop)
      pending_d[head_rd] = 1'b0;
    if (issue_set && (issue_rd != 5'd0))
      pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      we_q      <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      we_q      <= we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= lsu_rd;
      fifo_data_q[wptr_q] <= lsu_result;
    end
  end

  assign busy_rs1   = pending_q[chk_rs1];
  assign busy_rs2   = pending_q[chk_rs2];
  assign rd         = rd_q;
  assign result     = result_q;
  assign reg_write  = we_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random stimulus for writeback_unit against a queue-based
// reference model of the writeback rules.
module tb_writeback_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_result;
  logic            issue_set;
  logic [4:0]      issue_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            busy_rs1;
  logic            busy_rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] result;
  logic            reg_write;
  logic [2:0]      fifo_count;

  writeback_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_result(lsu_result),
    .issue_set(issue_set), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .rd(rd), .result(result), .reg_write(reg_write),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            q[$];
  logic [31:0]     m_pend;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_res;
  logic            m_we;
  bit              last_acc;
  int              n_assert;
  int              n_fail;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst        = 1'b0;
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_result = '0;
    lsu_valid  = 1'b0;
    lsu_rd     = '0;
    lsu_result = '0;
    issue_set  = 1'b0;
    issue_rd   = '0;
  endtask

  // one clock: check combinational outputs, advance model, check registers
  task automatic step();
    ent_t e;
    bit   acc;
    #2;
    chk("lsu_ready", 32'(lsu_ready),
        32'(!rst && (q.size() < DEPTH)));
    chk("busy_rs1", 32'(busy_rs1), 32'(m_pend[chk_rs1]));
    chk("busy_rs2", 32'(busy_rs2), 32'(m_pend[chk_rs2]));
    if (rst) begin
      q.delete();
      m_pend   = '0;
      m_rd     = '0;
      m_res    = '0;
      m_we     = 1'b0;
      last_acc = 1'b0;
    end else begin
      acc = lsu_valid && (q.size() < DEPTH);
      if (alu_valid) begin
        m_rd  = alu_rd;
        m_res = alu_result;
        m_we  = (alu_rd != 0);
      end else if (q.size() > 0) begin
        e     = q.pop_front();
        m_rd  = e.rd;
        m_res = e.d;
        m_we  = (e.rd != 0);
        m_pend[e.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (issue_set && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (acc) q.push_back('{lsu_rd, lsu_result});
      last_acc = acc;
    end
    m_pend[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("reg_write", 32'(reg_write), 32'(m_we));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("result", result, m_res);
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_pend   = '0;
    m_rd     = '0;
    m_res    = '0;
    m_we     = 1'b0;
    idle();
    chk_rs1 = 5'd0;
    chk_rs2 = 5'd0;
    rst     = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst_we", 32'(reg_write), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);

    // ALU only
    idle();
    alu_valid  = 1'b1;
    alu_rd     = 5'd5;
    alu_result = 32'hDEADBEEF;
    step();
    chk("alu_we", 32'(reg_write), 32'd1);
    chk("alu_rd", 32'(rd), 32'd5);
    chk("alu_res", result, 32'hDEADBEEF);
    alu_rd     = 5'd0;
    alu_result = 32'h1111_2222;
    step();
    chk("alu_x0_we", 32'(reg_write), 32'd0);
    idle();
    step();
    chk("idle_rd_hold", 32'(rd), 32'd0);

    // LSU with scoreboard
    idle();
    chk_rs1   = 5'd7;
    chk_rs2   = 5'd3;
    issue_set = 1'b1;
    issue_rd  = 5'd7;
    step();
    chk("sb_set", 32'(busy_rs1), 32'd1);
    idle();
    lsu_valid  = 1'b1;
    lsu_rd     = 5'd7;
    lsu_result = 32'h12345678;
    step();
    chk("sb_acc", 32'(last_acc), 32'd1);
    chk("sb_busyN1", 32'(busy_rs1), 32'd1);
    idle();
    step();
    chk("sb_we", 32'(reg_write), 32'd1);
    chk("sb_rd", 32'(rd), 32'd7);
    chk("sb_res", result, 32'h12345678);
    chk("sb_clr", 32'(busy_rs1), 32'd0);

    // contention: ALU busy while the FIFO fills
    for (int i = 0, k = 1; i < 6; i++) begin
      idle();
      alu_valid  = 1'b1;
      alu_rd     = 5'(20 + i);
      alu_result = 32'hA000_0000 + i;
      lsu_valid  = (k <= 5);
      lsu_rd     = 5'(k);
      lsu_result = 32'hB000_0000 + k;
      step();
      chk("cont_alu_rd", 32'(rd), 32'(20 + i));
      if (last_acc) k++;
    end
    chk("cont_full", 32'(fifo_count), 32'd4);
    chk("cont_ready", 32'(lsu_ready), 32'd0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("cont_drain_rd", 32'(rd), 32'(i));
    end
    chk("cont_empty", 32'(fifo_count), 32'd0);

    // wrap-around with back-to-back push/pop
    for (int i = 0; i < 10; i++) begin
      idle();
      lsu_valid  = 1'b1;
      lsu_rd     = 5'(10 + i);
      lsu_result = 32'hC000_0000 + i;
      step();
      chk("wrap_cnt_le2", 32'(fifo_count <= 2), 32'd1);
    end
    idle();
    step();
    chk("wrap_last", result, 32'hC000_0009);

    // set/clear collision on x9
    idle();
    chk_rs1   = 5'd9;
    issue_set = 1'b1;
    issue_rd  = 5'd9;
    step();
    idle();
    lsu_valid  = 1'b1;
    lsu_rd     = 5'd9;
    lsu_result = 32'h9999_0009;
    step();
    idle();
    issue_set = 1'b1;
    issue_rd  = 5'd9;
    step();
    chk("coll_pend", 32'(busy_rs1), 32'd1);
    chk("coll_rd", 32'(rd), 32'd9);

    // reset with entries buffered and x8..x11 pending
    for (int i = 8; i < 12; i++) begin
      idle();
      issue_set = 1'b1;
      issue_rd  = 5'(i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_valid  = 1'b1;
      alu_rd     = 5'd1;
      alu_result = 32'(i);
      lsu_valid  = 1'b1;
      lsu_rd     = 5'(8 + i);
      lsu_result = 32'hE000_0000 + i;
      step();
    end
    chk("rst_pre_cnt", 32'(fifo_count), 32'd3);
    idle();
    rst = 1'b1;
    step();
    chk("rst_mid_we", 32'(reg_write), 32'd0);
    chk("rst_mid_rd", 32'(rd), 32'd0);
    chk("rst_mid_res", result, 32'd0);
    chk("rst_mid_cnt", 32'(fifo_count), 32'd0);
    chk_rs1 = 5'd8;
    chk_rs2 = 5'd11;
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_write", 32'(reg_write), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      rst        = ($urandom_range(0, 49) == 0);
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_result = $urandom;
      lsu_valid  = ($urandom_range(0, 1) == 0);
      lsu_rd     = 5'($urandom_range(0, 31));
      lsu_result = $urandom;
      issue_set  = ($urandom_range(0, 2) == 0);
      issue_rd   = 5'($urandom_range(0, 31));
      chk_rs1    = 5'($urandom_range(0, 31));
      chk_rs2    = 5'($urandom_range(0, 31));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
